// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Holds the control state encoding and the counter-width calculation.
package serial_sub_pkg;

    localparam int N_DEFAULT = 128;
    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit operation still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n, input int w);
        int k;
        k = n / w;
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full-subtractor cell: diff = x - y - bi with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor_128.sv
// Digit-serial unsigned subtractor: d = (a - b - bin) mod 2^N, one W-bit digit per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module serial_subtractor_128
    import serial_sub_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output state_t       dbg_state
);

    localparam int K     = N / W;
    localparam int CNT_W = cnt_width(N, W);

    generate
        if (N % W != 0) begin : g_bad_width
            $error("serial_subtractor_128: N must be a multiple of W");
        end
    endgenerate

    state_t             state_q;
    state_t             state_n;
    logic [N-1:0]       a_sr;
    logic [N-1:0]       b_sr;
    logic [N-1:0]       d_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       q;
    logic [W:0]         chain;
    logic               last_step;

    // Borrow ripples through the W cells within a cycle, then is parked in borrow_q.
    assign chain[0] = borrow_q;
    generate
        for (genvar i = 0; i < W; i++) begin : g_cell
            full_subtractor u_cell (
                .x    (a_sr[i]),
                .y    (b_sr[i]),
                .bi   (chain[i]),
                .diff (q[i]),
                .bo   (chain[i+1])
            );
        end
    endgenerate

    assign last_step = (cnt_q == CNT_W'(K - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last_step) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == IDLE && in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            d_q      <= '0;
            borrow_q <= bin;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            // Digits enter at the top so digit 0 ends up in the low bits after K steps.
            a_sr     <= a_sr >> W;
            b_sr     <= b_sr >> W;
            d_q      <= {q, d_q[N-1:W]};
            borrow_q <= chain[W];
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = borrow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_128.sv
// Bench for serial_subtractor_128: vector table, random vectors, backpressure and mid-run reset.
module tb_serial_subtractor_128;
    import serial_sub_pkg::*;

    localparam int N = 128;
    localparam int W = 8;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] d;
    logic         bout;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;

    logic [N:0] exp_q[$];

    typedef struct {
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic         vbin;
        logic [N-1:0] exp_d;
        logic         exp_bout;
        int           stall;
        bit           pulse;
    } vec_t;

    vec_t vecs[5];

    serial_subtractor_128 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one operation, follow it through RUN, then check and drain the result.
    task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vbin,
                          input logic [N:0] exp, input int stall, input bit pulse);
        int wait_n;
        int lat;
        bit ready_seen;
        logic [N:0] want;
        wait_n = 0;
        @(negedge clk);
        while (!in_ready && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_accept", {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
        in_valid = 1'b1;
        a = va;
        b = vb;
        bin = vbin;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rand_word();
        b = rand_word();
        bin = 1'($urandom_range(0, 1));
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            if (pulse && lat == 5) begin
                in_valid = 1'b1;
                a = rand_word();
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", (N+1)'(lat), (N+1)'(K));
        check("in_ready_low_in_run", {{N{1'b0}}, ready_seen}, '0);
        check("no_ready_with_valid", {{N{1'b0}}, in_ready & out_valid}, '0);
        if (exp_q.size() == 0) begin
            check("queue_nonempty", '0, (N+1)'(1));
        end else begin
            want = exp_q.pop_front();
            check("result", {bout, d}, want);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                check("stall_valid", {{N{1'b0}}, out_valid}, (N+1)'(1));
                check("stall_data", {bout, d}, want);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_valid_low", {{N{1'b0}}, out_valid}, '0);
        check("drain_ready_high", {{N{1'b0}}, in_ready}, (N+1)'(1));
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbin;
        int           lat;
        ones = '1;

        vecs[0] = '{va: 128'd5,   vb: 128'd3, vbin: 1'b0, exp_d: 128'd2,   exp_bout: 1'b0, stall: 0, pulse: 1'b0};
        vecs[1] = '{va: 128'd0,   vb: 128'd1, vbin: 1'b0, exp_d: ones,     exp_bout: 1'b1, stall: 0, pulse: 1'b0};
        vecs[2] = '{va: 128'd256, vb: 128'd1, vbin: 1'b0, exp_d: 128'hFF,  exp_bout: 1'b0, stall: 0, pulse: 1'b0};
        vecs[3] = '{va: ones,     vb: ones,   vbin: 1'b1, exp_d: ones,     exp_bout: 1'b1, stall: 0, pulse: 1'b1};
        vecs[4] = '{va: 128'd1000, vb: 128'd999, vbin: 1'b1, exp_d: 128'd0, exp_bout: 1'b0, stall: 5, pulse: 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {{N{1'b0}}, in_ready}, (N+1)'(1));
        check("reset_out_valid", {{N{1'b0}}, out_valid}, '0);
        check("reset_d_bout", {bout, d}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, {vecs[i].exp_bout, vecs[i].exp_d},
                   vecs[i].stall, vecs[i].pulse);
        end

        // Random operands checked against plain wide arithmetic.
        for (int r = 0; r < 4; r++) begin
            ra = rand_word();
            rb = (r == 0) ? ra : rand_word();
            rbin = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbin, {1'b0, ra} - {1'b0, rb} - (N+1)'(rbin),
                   $urandom_range(0, 3), 1'b0);
        end

        // Reset landing mid-RUN discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a = 128'd77;
        b = 128'd99;
        bin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {{N{1'b0}}, out_valid}, '0);
        check("midreset_d_bout", {bout, d}, '0);
        check("midreset_in_ready", {{N{1'b0}}, in_ready}, (N+1)'(1));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(128'd100, 128'd58, 1'b0, {1'b0, 128'd42}, 0, 1'b0);

        // A clean idle stretch must not produce a stray result.
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("idle_no_output", (N+1)'(lat), '0);
        check("queue_empty", (N+1)'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
